serial_add_ctrl: RTL and testbench

Bit-serial addition controller. It time-multiplexes one external 1-bit full-adder cell across a WIDTH-bit addition, LSB first, and holds the running carry in a register. A start/busy/done handshake lets upstream logic add two WIDTH-bit operands using a single full-adder instance instead of a ripple chain.

---
 rtl/serial_add_ctrl.sv | 102 ++++++++++
 tb/tb_serial_add_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external full-adder cell LSB first
// across a WIDTH-bit addition, keeping the running carry in a register.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             last_bit;
    logic             running;

    assign last_bit = (idx == IDX_W'(WIDTH - 1));
    assign running  = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE always falls back to IDLE, so a start seen there is dropped rather than queued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a_in;
                        b_reg   <= b_in;
                        carry   <= cin;
                        idx     <= '0;
                        sum_out <= '0;
                    end
                end
                RUN: begin
                    sum_out[idx] <= fa_s;
                    carry        <= fa_cout;
                    if (last_bit) begin
                        cout_out <= fa_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The full-adder inputs are gated so the shared cell sees zeros outside RUN.
    assign fa_a = running & a_reg[idx];
    assign fa_b = running & b_reg[idx];
    assign fa_c = running & carry;
    assign busy = running;
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 main instance plus a WIDTH=1 instance,
// each wired to a behavioural full-adder cell.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         fa_a, fa_b, fa_c, fa_s, fa_cout;
    logic         busy, done;
    logic [W-1:0] sum_out;
    logic         cout_out;

    logic         start1;
    logic [0:0]   a1, b1;
    logic         cin1;
    logic         fa_a1, fa_b1, fa_c1, fa_s1, fa_cout1;
    logic         busy1, done1;
    logic [0:0]   sum1;
    logic         cout1;

    int tests = 0;
    int fails = 0;
    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1), .fa_s(fa_s1), .fa_cout(fa_cout1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1)
    );

    assign fa_s     = fa_a ^ fa_b ^ fa_c;
    assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
    assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_c1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_c1) | (fa_b1 & fa_c1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
    endtask

    // Drives one start, pushes the expected result and waits (bounded) for done.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output bit got, output int lat);
        wait_idle();
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        exp_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(c));
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= W + 6; i++) begin
            if (done) begin
                got = 1'b1;
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, cout_out, sum_out} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout_out, sum_out);
        end
        tests++;
        if ({fa_a, fa_b, fa_c} !== 3'b000) begin
            fails++;
            $display("FAIL reset_fa: fa=%b%b%b, want 000", fa_a, fa_b, fa_c);
        end
        start = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_vs_start: busy=%b, want 0", busy);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   e;
        a = 8'h5A; b = 8'h3C; c = 1'b0;
        wait_idle();
        a_in = a; b_in = b; cin = c; start = 1'b1;
        exp_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(c));
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            tests++;
            if ({busy, fa_a, fa_b, fa_c} !== {1'b1, a[k], b[k], c}) begin
                fails++;
                $display("FAIL basic_bit%0d: busy=%b fa=%b%b%b, want 1 %b%b%b", k, busy, fa_a, fa_b, fa_c, a[k], b[k], c);
            end
            c = (a[k] & b[k]) | (a[k] & c) | (b[k] & c);
            a_in = ~a_in;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        tests++;
        if ({done, busy, cout_out, sum_out} !== {1'b1, 1'b0, e}) begin
            fails++;
            $display("FAIL basic_result: done=%b busy=%b cout=%b sum=%h, want 1 0 %b %h", done, busy, cout_out, sum_out, e[W], e[W-1:0]);
        end
        @(negedge clk);
        tests++;
        if ({done, fa_a, fa_b, fa_c} !== 4'b0000 || sum_out !== e[W-1:0]) begin
            fails++;
            $display("FAIL basic_after: done=%b fa=%b%b%b sum=%h, want 0 000 %h", done, fa_a, fa_b, fa_c, sum_out, e[W-1:0]);
        end
    endtask

    task automatic test_carry();
        bit         got;
        int         lat;
        logic [W:0] e;
        logic [W-1:0] av[2] = '{8'hFF, 8'hFF};
        logic [W-1:0] bv[2] = '{8'h01, 8'hFF};
        logic         cv[2] = '{1'b0, 1'b1};
        for (int t = 0; t < 2; t++) begin
            do_add(av[t], bv[t], cv[t], got, lat);
            e = exp_q.pop_front();
            tests++;
            if (!got || lat != W + 1) begin
                fails++;
                $display("FAIL carry%0d_latency: got=%0d lat=%0d, want 1 %0d", t, got, lat, W + 1);
            end
            tests++;
            if ({cout_out, sum_out} !== e) begin
                fails++;
                $display("FAIL carry%0d_result: %h, want %h", t, {cout_out, sum_out}, e);
            end
        end
    endtask

    task automatic test_start_held();
        int         pulses = 0;
        logic [W:0] e;
        wait_idle();
        a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h002);
        for (int cyc = 1; cyc <= 2 * W + 6; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                a_in = 8'h10;
                exp_q.push_back(9'h011);
            end
            if (cyc == W + 2) begin
                tests++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL held_idle_gap: busy=%b done=%b, want 0 0", busy, done);
                end
            end
            if (cyc == W + 3) begin
                start = 1'b0;
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL held_second_accept: busy=%b, want 1", busy);
                end
            end
            if (done) begin
                pulses++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL held_extra_done: cycle %0d, scoreboard empty", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({cout_out, sum_out} !== e || (cyc != W + 1 && cyc != 2 * W + 3)) begin
                        fails++;
                        $display("FAIL held_result: cycle %0d value %h, want %h at cycle %0d/%0d", cyc, {cout_out, sum_out}, e, W + 1, 2 * W + 3);
                    end
                end
            end
        end
        start = 1'b0;
        tests++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL held_pulses: %0d done pulses, want 2", pulses);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        wait_idle();
        a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b1 || sum_out !== 8'h07) begin
            fails++;
            $display("FAIL midrun_partial: busy=%b sum=%h, want 1 07", busy, sum_out);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, cout_out, sum_out, fa_a, fa_b, fa_c} !== '0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b done=%b cout=%b sum=%h fa=%b%b%b, want all 0", busy, done, cout_out, sum_out, fa_a, fa_b, fa_c);
        end
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL midrun_no_done: %0d active cycles after reset, want 0", pulses);
        end
    endtask

    task automatic test_width1();
        logic [1:0] e;
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        e = 2'(a1) + 2'(b1) + 2'(cin1);
        @(negedge clk);
        start1 = 1'b0;
        tests++;
        if ({busy1, done1, fa_a1, fa_b1, fa_c1} !== 5'b10111) begin
            fails++;
            $display("FAIL w1_run: busy=%b done=%b fa=%b%b%b, want 1 0 111", busy1, done1, fa_a1, fa_b1, fa_c1);
        end
        @(negedge clk);
        tests++;
        if ({busy1, done1, cout1, sum1} !== {2'b01, e}) begin
            fails++;
            $display("FAIL w1_done: busy=%b done=%b cout=%b sum=%b, want 0 1 %b", busy1, done1, cout1, sum1, e);
        end
        @(negedge clk);
        tests++;
        if ({busy1, done1} !== 2'b00) begin
            fails++;
            $display("FAIL w1_idle: busy=%b done=%b, want 0 0", busy1, done1);
        end
    endtask

    task automatic test_random();
        bit         got;
        int         lat;
        logic [W:0] e;
        for (int n = 0; n < 1000; n++) begin
            do_add(W'($urandom), W'($urandom), 1'($urandom), got, lat);
            e = exp_q.pop_front();
            tests++;
            if (!got || lat != W + 1 || {cout_out, sum_out} !== e) begin
                fails++;
                $display("FAIL rand%0d: got=%0d lat=%0d value %h, want lat %0d value %h", n, got, lat, {cout_out, sum_out}, W + 1, e);
            end
            a_in = W'($urandom);
            b_in = W'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            tests++;
            if ({cout_out, sum_out} !== e) begin
                fails++;
                $display("FAIL rand%0d_hold: value %h, want %h", n, {cout_out, sum_out}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_held();
        test_reset_mid();
        test_width1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
